// File: rtl/alu_exec_stage.sv
// Execute/writeback stage closing the loop on an 8x8 register file: IDLE -> READ -> EXEC -> WB.
// Optional feature macro ALU_EXEC_MUL_EN: op 7 becomes an 8-cycle shift-add MUL; otherwise op 7 is a NOP.
module alu_exec_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs1,
    input  logic [ADDR_W-1:0] instr_rs2,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              flag_zero,
    output logic              flag_carry,
    output logic              busy
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_LDI = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_ready;
    logic                r_busy;
    logic [2:0]          r_op;
    logic [ADDR_W-1:0]   r_rd;
    logic [DATA_W-1:0]   r_imm;
    logic [ADDR_W-1:0]   r_rd_addr1;
    logic [ADDR_W-1:0]   r_rd_addr2;
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic [DATA_W:0]     r_result;
    logic                r_wr_en;
    logic                r_flag_zero;
    logic                r_flag_carry;
    logic                w_accept;
    logic                w_exec_done;
    logic                w_writes;
    logic [DATA_W:0]     w_alu;

`ifdef ALU_EXEC_MUL_EN
    localparam int CNT_W = $clog2(DATA_W);
    logic [2*DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [2*DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]    r_mul_cnt;
    logic [2*DATA_W-1:0] w_acc_next;

    assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : {(2*DATA_W){1'b0}});
    assign w_exec_done = (r_op != OP_MUL) || (r_mul_cnt == CNT_W'(DATA_W - 1));
    assign w_writes    = 1'b1;
`else
    assign w_exec_done = 1'b1;
    assign w_writes    = (r_op != OP_MUL);
`endif

    assign w_accept = (r_state == S_IDLE) && r_ready && instr_valid;

    // Result of the current EXEC cycle; bit DATA_W carries carry/borrow.
    always_comb begin
        w_alu = '0;
        case (r_op)
            OP_ADD:  w_alu = {1'b0, r_op_a} + {1'b0, r_op_b};
            OP_SUB:  w_alu = {1'b0, r_op_a} - {1'b0, r_op_b};
            OP_AND:  w_alu = {1'b0, r_op_a & r_op_b};
            OP_OR:   w_alu = {1'b0, r_op_a | r_op_b};
            OP_XOR:  w_alu = {1'b0, r_op_a ^ r_op_b};
            OP_SHL:  w_alu = {r_op_a, 1'b0};
            OP_LDI:  w_alu = {1'b0, r_imm};
`ifdef ALU_EXEC_MUL_EN
            OP_MUL:  w_alu = {|w_acc_next[2*DATA_W-1:DATA_W], w_acc_next[DATA_W-1:0]};
`endif
            default: w_alu = '0;
        endcase
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_READ;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_READ: w_state_next = S_EXEC;
            S_EXEC: begin
                if (w_exec_done) begin
                    w_state_next = S_WB;
                end else begin
                    w_state_next = S_EXEC;
                end
            end
            S_WB:    w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Instruction capture, operand latch, result and writeback/flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_op         <= 3'd0;
            r_rd         <= '0;
            r_imm        <= '0;
            r_rd_addr1   <= '0;
            r_rd_addr2   <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_result     <= '0;
            r_wr_en      <= 1'b0;
            r_flag_zero  <= 1'b0;
            r_flag_carry <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_acc        <= '0;
            r_mul_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_op       <= instr_op;
                        r_rd       <= instr_rd;
                        r_imm      <= instr_imm;
                        r_rd_addr1 <= instr_rs1;
                        r_rd_addr2 <= instr_rs2;
                    end else begin
                        r_ready    <= 1'b1;
                    end
                end
                S_READ: begin
                    r_op_a    <= rd_data1;
                    r_op_b    <= rd_data2;
`ifdef ALU_EXEC_MUL_EN
                    r_mcand   <= {{DATA_W{1'b0}}, rd_data1};
                    r_mplier  <= rd_data2;
                    r_acc     <= '0;
                    r_mul_cnt <= '0;
`endif
                end
                S_EXEC: begin
`ifdef ALU_EXEC_MUL_EN
                    r_acc     <= w_acc_next;
                    r_mcand   <= r_mcand << 1;
                    r_mplier  <= r_mplier >> 1;
                    r_mul_cnt <= r_mul_cnt + CNT_W'(1);
`endif
                    if (w_exec_done) begin
                        r_result <= w_alu;
                        r_wr_en  <= w_writes;
                    end else begin
                        r_wr_en  <= 1'b0;
                    end
                end
                S_WB: begin
                    r_wr_en <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    // A NOP leaves the previous flags in place.
                    if (w_writes) begin
                        r_flag_zero  <= (r_result[DATA_W-1:0] == {DATA_W{1'b0}});
                        r_flag_carry <= r_result[DATA_W];
                    end else begin
                        r_flag_zero  <= r_flag_zero;
                        r_flag_carry <= r_flag_carry;
                    end
                end
                default: begin
                    r_wr_en <= 1'b0;
                end
            endcase
        end
    end

    assign instr_ready = r_ready;
    assign busy        = r_busy;
    assign rd_addr1    = r_rd_addr1;
    assign rd_addr2    = r_rd_addr2;
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_rd;
    assign wr_data     = r_result[DATA_W-1:0];
    assign flag_zero   = r_flag_zero;
    assign flag_carry  = r_flag_carry;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: behavioural register file, write scoreboard, per-scenario tasks.
module tb_alu_exec_stage;

`ifdef ALU_EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [2:0] instr_rd, instr_rs1, instr_rs2;
    logic [7:0] instr_imm;
    logic [2:0] rd_addr1, rd_addr2;
    logic [7:0] rd_data1, rd_data2;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       flag_zero, flag_carry, busy;

    logic [7:0] regs [8];
    logic       rf_clear;

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    int   checks = 0;
    int   errors = 0;
    logic exp_z  = 1'b0;
    logic exp_c  = 1'b0;

    alu_exec_stage #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
        .instr_rs2(instr_rs2), .instr_imm(instr_imm),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .flag_zero(flag_zero), .flag_carry(flag_carry), .busy(busy)
    );

    always #5 clk = ~clk;

    assign rd_data1 = regs[rd_addr1];
    assign rd_data2 = regs[rd_addr2];

    always_ff @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Issue one instruction, check read addresses, write timing/content, ready return and flags.
    task automatic run_instr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                             input logic [2:0] rs2, input logic [7:0] imm);
        int a, b, p, lat, seen, t;
        bit wr;
        logic [7:0] ed;
        logic ec;
        exp_t e;
        a = int'(regs[rs1]);
        b = int'(regs[rs2]);
        ec = 1'b0;
        p = 0;
        case (op)
            3'd0: begin p = a + b; ec = (p > 255); end
            3'd1: begin p = a - b; ec = (p < 0); end
            3'd2: p = a & b;
            3'd3: p = a | b;
            3'd4: p = a ^ b;
            3'd5: begin p = a * 2; ec = (a >= 128); end
            3'd6: p = int'(imm);
            default: begin p = a * b; ec = (p > 255); end
        endcase
        ed  = p[7:0];
        wr  = (op != 3'd7) || MUL_EN;
        lat = (op == 3'd7 && MUL_EN) ? 10 : 3;
        t = 0;
        while (!instr_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout op=%0d got %b exp 1", op, instr_ready);
            return;
        end
        instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr_op = 3'($urandom); instr_rd = 3'($urandom);
        instr_rs1 = 3'($urandom); instr_rs2 = 3'($urandom); instr_imm = 8'($urandom);
        if (wr) begin
            e.addr = rd;
            e.data = ed;
            sb.push_back(e);
            exp_z = (ed == 8'h00);
            exp_c = ec;
        end
        seen = 0;
        for (int cyc = 1; cyc <= lat + 2; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                checks++;
                if (rd_addr1 !== rs1 || rd_addr2 !== rs2 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL read_addr op=%0d got %0d/%0d busy %b exp %0d/%0d busy 1",
                             op, rd_addr1, rd_addr2, busy, rs1, rs2);
                end
            end
            if (cyc == lat) begin
                checks++;
                if (instr_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_during_wb op=%0d got %b exp 0", op, instr_ready);
                end
            end
            if (cyc == lat + 1) begin
                checks++;
                if (instr_ready !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_return op=%0d got ready %b busy %b exp 1 0", op, instr_ready, busy);
                end
            end
            if (wr_en === 1'b1) begin
                seen++;
                checks++;
                if (cyc != lat) begin
                    errors++;
                    $display("FAIL wr_timing op=%0d got cycle %0d exp %0d", op, cyc, lat);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write op=%0d got addr %0d data %h exp none", op, wr_addr, wr_data);
                end else begin
                    e = sb.pop_front();
                    if (wr_addr !== e.addr || wr_data !== e.data) begin
                        errors++;
                        $display("FAIL wr_content op=%0d got %0d:%h exp %0d:%h", op, wr_addr, wr_data, e.addr, e.data);
                    end
                end
            end
        end
        checks++;
        if (seen != (wr ? 1 : 0)) begin
            errors++;
            $display("FAIL wr_count op=%0d got %0d exp %0d", op, seen, wr ? 1 : 0);
        end
        checks++;
        if (flag_zero !== exp_z || flag_carry !== exp_c) begin
            errors++;
            $display("FAIL flags op=%0d got z%b c%b exp z%b c%b", op, flag_zero, flag_carry, exp_z, exp_c);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rf_clear = 1'b1;
        instr_valid = 1'b1;
        instr_op = 3'd6; instr_rd = 3'd5; instr_rs1 = 3'd1; instr_rs2 = 3'd2; instr_imm = 8'h11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 3'd0 ||
            wr_data !== 8'h00 || rd_addr1 !== 3'd0 || rd_addr2 !== 3'd0 ||
            flag_zero !== 1'b0 || flag_carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got rdy%b busy%b we%b wa%0d wd%h ra%0d/%0d z%b c%b exp all 0",
                     instr_ready, busy, wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, flag_zero, flag_carry);
        end
        instr_valid = 1'b0;
        reset = 1'b0;
        rf_clear = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_reset got rdy%b busy%b exp 1 0", instr_ready, busy);
        end
    endtask

    task automatic test_ldi;
        run_instr(3'd6, 3'd3, 3'd0, 3'd0, 8'h5A);
        run_instr(3'd6, 3'd1, 3'd0, 3'd0, 8'hF0);
        run_instr(3'd6, 3'd2, 3'd0, 3'd0, 8'h20);
        run_instr(3'd6, 3'd4, 3'd0, 3'd0, 8'h05);
        run_instr(3'd6, 3'd5, 3'd0, 3'd0, 8'h03);
        run_instr(3'd6, 3'd6, 3'd0, 3'd0, 8'h12);
        run_instr(3'd6, 3'd7, 3'd0, 3'd0, 8'h10);
    endtask

    task automatic test_add_sub;
        run_instr(3'd0, 3'd0, 3'd1, 3'd2, 8'h00);
        run_instr(3'd1, 3'd0, 3'd4, 3'd4, 8'h00);
        run_instr(3'd1, 3'd0, 3'd5, 3'd4, 8'h00);
    endtask

    task automatic test_reset_mid;
        int seen;
        seen = 0;
        @(negedge clk);
        instr_op = 3'd0; instr_rd = 3'd3; instr_rs1 = 3'd1; instr_rs2 = 3'd2; instr_imm = 8'h00;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (wr_en === 1'b1) seen++;
            if (cyc == 2) reset = 1'b1;
            if (cyc == 3) begin
                checks++;
                if (instr_ready !== 1'b0 || busy !== 1'b0 || flag_zero !== 1'b0 || flag_carry !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_state got rdy%b busy%b z%b c%b exp 0 0 0 0",
                             instr_ready, busy, flag_zero, flag_carry);
                end
                reset = 1'b0;
            end
            if (cyc == 4) begin
                checks++;
                if (instr_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_ready got %b exp 1", instr_ready);
                end
            end
        end
        checks++;
        if (seen != 0 || regs[3] !== 8'h5A) begin
            errors++;
            $display("FAIL abort_no_write got writes %0d r3 %h exp 0 5a", seen, regs[3]);
        end
        exp_z = 1'b0;
        exp_c = 1'b0;
    endtask

    task automatic test_logic_shift;
        run_instr(3'd2, 3'd0, 3'd1, 3'd7, 8'h00);
        run_instr(3'd3, 3'd0, 3'd4, 3'd2, 8'h00);
        run_instr(3'd5, 3'd0, 3'd1, 3'd0, 8'h00);
        run_instr(3'd4, 3'd1, 3'd1, 3'd2, 8'h00);
        run_instr(3'd4, 3'd1, 3'd1, 3'd1, 8'h00);
    endtask

    task automatic test_mul;
        run_instr(3'd6, 3'd2, 3'd0, 3'd0, 8'h33);
        run_instr(3'd7, 3'd0, 3'd6, 3'd7, 8'h00);
        run_instr(3'd7, 3'd0, 3'd2, 3'd2, 8'h00);
    endtask

    task automatic test_back_to_back;
        int seen, prev;
        exp_t e;
        seen = 0;
        prev = 0;
        @(negedge clk);
        instr_op = 3'd6; instr_rd = 3'd0; instr_rs1 = 3'd0; instr_rs2 = 3'd0; instr_imm = 8'h77;
        instr_valid = 1'b1;
        e.addr = 3'd0;
        e.data = 8'h77;
        sb.push_back(e);
        sb.push_back(e);
        @(posedge clk);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc == 7) instr_valid = 1'b0;
            if (wr_en === 1'b1) begin
                seen++;
                checks++;
                if ((cyc != 3 && cyc != 7) || prev == 1) begin
                    errors++;
                    $display("FAIL b2b_timing got cycle %0d prev %0d exp cycle 3 or 7 prev 0", cyc, prev);
                end
                e = sb.pop_front();
                checks++;
                if (wr_addr !== e.addr || wr_data !== e.data) begin
                    errors++;
                    $display("FAIL b2b_content got %0d:%h exp %0d:%h", wr_addr, wr_data, e.addr, e.data);
                end
                prev = 1;
            end else begin
                prev = 0;
            end
        end
        checks++;
        if (seen != 2 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_count got %0d left %0d exp 2 0", seen, sb.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        rf_clear = 1'b1;
        instr_valid = 1'b0;
        instr_op = 3'd0; instr_rd = 3'd0; instr_rs1 = 3'd0; instr_rs2 = 3'd0; instr_imm = 8'h00;
        test_reset();
        test_ldi();
        test_add_sub();
        test_reset_mid();
        test_logic_shift();
        test_mul();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
